// File: rtl/core_stdout_uart_pkg.sv
// Shared types and helpers for the stdout UART printer.
package core_stdout_uart_pkg;

  // Word formatter states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } fmt_state_e;

  // Byte serializer states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

  localparam logic [7:0] ASCII_NL = 8'h0A;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/core_uart_tx.sv
// 8N1 byte serializer with a registered, glitch-free TX output.
module core_uart_tx
  import core_stdout_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       val_i,
  input  logic [7:0] data_i,
  output logic       rdy_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;

  // State registers; reset forces the line idle-high at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: each state/bit lasts CLKS_PER_BIT cycles; tx_d is the next line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        if (val_i) begin
          state_d = S_START;
          cnt_d   = CntMax;
          sh_d    = data_i;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CntMax;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CntMax;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy_o = (state_q == S_IDLE);
  assign tx_o  = tx_q;

endmodule

// File: rtl/core_stdout_uart.sv
// Buffers 16-bit stdout words and prints each as "HHHH\n" over an 8N1 UART.
module core_stdout_uart
  import core_stdout_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stdout_val_i,
  output logic        stdout_rdy_o,
  input  logic [15:0] stdout_data_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            push, pop;

  fmt_state_e  fmt_q, fmt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  chr;
  logic        ser_val, ser_rdy;

  // rdy depends only on the registered count, never on val.
  assign stdout_rdy_o = (cnt_q != FullCnt);
  assign push         = stdout_val_i && stdout_rdy_o;
  assign busy_o       = (cnt_q != '0) || (fmt_q != IDLE);

  // FIFO storage; contents need no reset since cnt_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= stdout_data_i;
    end
  end

  // Pointer, count and formatter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      fmt_q  <= IDLE;
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      fmt_q  <= fmt_d;
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Formatter: pop a word, then feed four hex digits and a newline to the serializer.
  always_comb begin
    fmt_d   = fmt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    pop     = 1'b0;
    ser_val = 1'b0;
    unique case (fmt_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop    = 1'b1;
          word_d = mem_q[rptr_q];
          idx_d  = 3'd0;
          fmt_d  = LOAD;
        end
      end
      LOAD: begin
        ser_val = 1'b1;
        fmt_d   = SEND;
      end
      SEND: begin
        if (ser_rdy) begin
          if (idx_q < 3'd4) begin
            idx_d = idx_q + 3'd1;
            fmt_d = LOAD;
          end else if (cnt_q != '0) begin
            // Chain straight into the next word to keep the line gap short.
            pop    = 1'b1;
            word_d = mem_q[rptr_q];
            idx_d  = 3'd0;
            fmt_d  = LOAD;
          end else begin
            fmt_d = IDLE;
          end
        end
      end
      default: fmt_d = IDLE;
    endcase
  end

  // Character select for the current index.
  always_comb begin
    chr = ASCII_NL;
    unique case (idx_q)
      3'd0:    chr = hex2ascii(word_q[15:12]);
      3'd1:    chr = hex2ascii(word_q[11:8]);
      3'd2:    chr = hex2ascii(word_q[7:4]);
      3'd3:    chr = hex2ascii(word_q[3:0]);
      default: chr = ASCII_NL;
    endcase
  end

  core_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .val_i (ser_val),
    .data_i(chr),
    .rdy_o (ser_rdy),
    .tx_o  (tx_o)
  );

endmodule

// File: tb/tb_core_stdout_uart.sv
// Scoreboard bench: words pushed produce expected ASCII bytes; a UART monitor decodes tx_o.
module tb_core_stdout_uart;

  localparam int unsigned CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val = 1'b0;
  logic [15:0] data = '0;
  logic        rdy, tx, busy;

  core_stdout_uart #(
    .CLK_HZ    (8),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stdout_val_i (val),
    .stdout_rdy_o (rdy),
    .stdout_data_i(data),
    .tx_o         (tx),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];
  string hexd = "0123456789ABCDEF";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a word prints as its four uppercase hex digits, most significant first, then LF.
  task automatic expect_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = (int'(w) >> (12 - 4 * i)) & 15;
      exp_q.push_back(hexd[n]);
    end
    exp_q.push_back(8'h0A);
  endtask

  // Called at a negedge; returns #1 after the handshake edge.
  task automatic push_word(input logic [15:0] w, input bit keep_val, output int stalls);
    data   = w;
    val    = 1'b1;
    stalls = 0;
    while (!rdy && stalls < 2000) begin
      @(negedge clk);
      stalls++;
    end
    if (!rdy) begin
      chk("push_timeout", 32'(rdy), 32'd1);
      val = 1'b0;
    end else begin
      @(posedge clk);
      expect_word(w);
      #1;
      if (!keep_val) val = 1'b0;
    end
  endtask

  // Wait for busy_o to fall; by then every expected byte must have appeared.
  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", 32'(busy), 32'd0);
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
  endtask

  // UART monitor: sample mid-bit, abandon the frame on reset.
  always begin : monitor
    logic [9:0] bits;
    bit         aborted;
    logic [7:0] e;
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      start_cyc.push_back(cyc);
      aborted = 1'b0;
      for (int b = 0; b < 10; b++) begin
        repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        bits[b] = tx;
      end
      if (!aborted) begin
        frames_seen++;
        chk("start_bit", 32'(bits[0]), 32'd0);
        chk("stop_bit", 32'(bits[9]), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none", bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(bits[8:1]), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    int k;
    int s0;
    int f0;
    int stalls[6];
    logic [15:0] w;

    // Reset state, then an idle line for 100 cycles.
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_line", 32'({tx, busy, rdy}), 32'b101);
    end
    chk("no_frames", 32'(frames_seen), 32'd0);

    // Single word with start-bit latency: tx falls after the 2nd edge following the handshake.
    @(negedge clk);
    push_word(16'h1A2F, 1'b0, st);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (tx == 1'b0) begin
        k = i;
        break;
      end
    end
    chk("start_latency", 32'(k), 32'd2);
    wait_idle(2000);
    chk("frames_1a2f", 32'(frames_seen), 32'd5);

    // Back-to-back words: at most one bit-time between the LF and the next word.
    s0 = start_cyc.size();
    @(negedge clk);
    push_word(16'h0000, 1'b0, st);
    @(negedge clk);
    push_word(16'hFFFF, 1'b0, st);
    wait_idle(3000);
    if (start_cyc.size() >= s0 + 6) begin
      k = start_cyc[s0 + 5] - start_cyc[s0 + 4] - 10 * CPB;
      chk("word_gap", 32'(k <= int'(CPB)), 32'd1);
    end else begin
      chk("word_gap_frames", 32'(start_cyc.size() - s0), 32'd10);
    end

    // Six words with val held: five accepted without stall, the sixth waits for a pop.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      push_word(w, i < 5, stalls[i]);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) chk("no_stall", 32'(stalls[i]), 32'd0);
    chk("sixth_stalled", 32'(stalls[5] > 0), 32'd1);
    wait_idle(6000);

    // Pointers wrap during a simultaneous push and pop; count must stay put.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      push_word(w, i < 4, stalls[i]);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) chk("wrap_no_stall", 32'(stalls[i]), 32'd0);
    wait_idle(6000);

    // Reset during the second digit of BEEF.
    s0 = start_cyc.size();
    @(negedge clk);
    push_word(16'hBEEF, 1'b0, st);
    k = 0;
    while (start_cyc.size() < s0 + 2 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("second_digit_seen", 32'(start_cyc.size() >= s0 + 2), 32'd1);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdy", 32'(rdy), 32'd1);
    exp_q.delete();
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    f0 = frames_seen;
    push_word(16'h0042, 1'b0, st);
    wait_idle(2000);
    chk("frames_0042", 32'(frames_seen - f0), 32'd5);

    // Random words with random idle gaps.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      w = 16'($urandom);
      push_word(w, 1'b0, st);
      repeat ($urandom_range(0, 450)) @(negedge clk);
    end
    wait_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
